// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for MUL, UMULL and SMULL.
// Define MUL_SEQ_EARLY_TERM_EN to end RUN once the remaining multiplier bits are zero.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       MulOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       MulFlags
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic                 sign_r;
  logic                 long_r;

  logic [2*WIDTH-1:0]   add_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     shifted_s;
  logic [WIDTH-1:0]     lo_s;
  logic [WIDTH-1:0]     hi_s;
  logic                 last_s;
  logic                 n_s;
  logic                 z_s;
  logic                 op_smull_s;
  logic                 op_long_s;

  // Magnitude of a signed operand; the most negative value maps onto 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      mag = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag = x;
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2w(input logic [2*WIDTH-1:0] x);
    neg2w = ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Status decode from state.
  always_comb begin
    busy = (state_r == RUN) || (state_r == DONE);
    done = (state_r == DONE);
  end

  // Datapath for one iteration and the product / flag values written on the final one.
  always_comb begin
    op_smull_s = (MulOp == 2'b10);
    op_long_s  = (MulOp == 2'b01) || (MulOp == 2'b10);
    add_s      = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    shifted_s  = mplier_r >> 1;
`ifdef MUL_SEQ_EARLY_TERM_EN
    last_s     = (cnt_r == CW'(WIDTH-1)) || (shifted_s == {WIDTH{1'b0}});
`else
    last_s     = (cnt_r == CW'(WIDTH-1));
`endif
    prod_s     = sign_r ? neg2w(add_s) : add_s;
    lo_s       = prod_s[WIDTH-1:0];
    hi_s       = long_r ? prod_s[2*WIDTH-1:WIDTH] : {WIDTH{1'b0}};
    n_s        = long_r ? hi_s[WIDTH-1] : lo_s[WIDTH-1];
    z_s        = long_r ? (prod_s == {(2*WIDTH){1'b0}}) : (lo_s == {WIDTH{1'b0}});
  end

  // Sequencer FSM with operand latches, accumulator and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      sign_r   <= 1'b0;
      long_r   <= 1'b0;
      ResultLo <= {WIDTH{1'b0}};
      ResultHi <= {WIDTH{1'b0}};
      MulFlags <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            long_r  <= op_long_s;
            if (op_smull_s) begin
              mcand_r  <= {{WIDTH{1'b0}}, mag(SrcA)};
              mplier_r <= mag(SrcB);
              sign_r   <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
            end else begin
              mcand_r  <= {{WIDTH{1'b0}}, SrcA};
              mplier_r <= SrcB;
              sign_r   <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // Shifting mcand each cycle is the same as adding mcand << counter.
          acc_r    <= add_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= shifted_s;
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            state_r  <= DONE;
            ResultLo <= lo_s;
            ResultHi <= hi_s;
            MulFlags <= {n_s, z_s};
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq (WIDTH=32); latencies follow MUL_SEQ_EARLY_TERM_EN if defined.
module tb_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  MulOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] ResultLo;
  logic [31:0] ResultHi;
  logic [1:0]  MulFlags;

  int vectors = 0;
  int errors  = 0;
  int lat;
  int seen;

`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mul_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .MulOp    (MulOp),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .busy     (busy),
    .done     (done),
    .ResultLo (ResultLo),
    .ResultHi (ResultHi),
    .MulFlags (MulFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input int full, input int early);
    exp_lat = EARLY ? early : full;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start in cycle 0 and return in the done cycle; inj>0 raises start again in that cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int l);
    @(negedge clk);
    start = 1'b1; MulOp = op; SrcA = a; SrcB = b;
    l = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == inj) begin
        start = 1'b1; MulOp = 2'b01; SrcA = 32'h0000_0003; SrcB = 32'h0000_0009;
      end else begin
        start = 1'b0; MulOp = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
      end
      if (done) begin
        l = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                           input logic [1:0] fl);
    check({tag, "_hi"}, 64'(ResultHi), 64'(hi));
    check({tag, "_lo"}, 64'(ResultLo), 64'(lo));
    check({tag, "_flags"}, 64'(MulFlags), 64'(fl));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MulOp = 2'b00; SrcA = 32'h0; SrcB = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_res("rst", 32'h0, 32'h0, 2'b00);
    reset = 1'b0;

    // MUL 7*6, then UMULL back-to-back (start in cycle lat+1)
    run_op(2'b00, 32'd7, 32'd6, 0, lat);
    check("t1_lat", 64'(lat), 64'(exp_lat(33, 4)));
    check_res("t1", 32'h0, 32'd42, 2'b00);
    check("t1_busy", 64'(busy), 64'd1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat);
    check("t2_lat", 64'(lat), 64'(exp_lat(33, 33)));
    check_res("t2", 32'hFFFF_FFFE, 32'h0000_0001, 2'b10);

    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 0, lat);
    check("t3a_lat", 64'(lat), 64'(exp_lat(33, 4)));
    check_res("t3a", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2'b10);
    run_op(2'b10, 32'h8000_0000, 32'h8000_0000, 0, lat);
    check("t3b_lat", 64'(lat), 64'(exp_lat(33, 33)));
    check_res("t3b", 32'h4000_0000, 32'h0, 2'b00);
    run_op(2'b10, 32'd3, 32'hFFFF_FFFB, 0, lat);
    check_res("t3c", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2'b10);
    run_op(2'b10, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 0, lat);
    check_res("t3d", 32'h0, 32'h0000_000F, 2'b00);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, lat);
    check_res("t3e_mulneg", 32'h0, 32'hFFFF_FFF1, 2'b10);

    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 0, lat);
    check("t4a_lat", 64'(lat), 64'(exp_lat(33, 18)));
    check_res("t4a", 32'h0, 32'h0, 2'b01);
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 0, lat);
    check_res("t4b", 32'h1, 32'h0, 2'b00);
    run_op(2'b11, 32'h0001_0000, 32'h0001_0000, 0, lat);
    check_res("t4c_rsvd", 32'h0, 32'h0, 2'b01);

    // Second start while running must be ignored
    run_op(2'b00, 32'd7, 32'd6, exp_lat(5, 2), lat);
    check("t5a_lat", 64'(lat), 64'(exp_lat(33, 4)));
    check_res("t5a", 32'h0, 32'd42, 2'b00);
    @(negedge clk);
    check("t5a_idle", 64'(busy), 64'd0);

    // Reset in cycle 10 of a long operation abandons it
    @(negedge clk);
    start = 1'b1; MulOp = 2'b01; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t5b_busy9", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t5b_busy11", 64'(busy), 64'd0);
    check("t5b_done11", 64'(done), 64'd0);
    check_res("t5b", 32'h0, 32'h0, 2'b00);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("t5b_nodone", 64'(seen), 64'd0);

    run_op(2'b00, 32'h1234_5678, 32'h0, 0, lat);
    check("t6_lat", 64'(lat), 64'(exp_lat(33, 2)));
    check_res("t6", 32'h0, 32'h0, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
